// File: rtl/muldiv_unit_if.sv
// rtl/muldiv_unit_if.sv - request/result bundle between the register file and the RV32M muldiv unit
interface muldiv_unit_if #(
    parameter int REG_NUM_BITWIDTH = 5,
    parameter int WORD_BITWIDTH    = 32
);
    logic                        start;
    logic [2:0]                  funct3;
    logic [WORD_BITWIDTH-1:0]    rs1_data;
    logic [WORD_BITWIDTH-1:0]    rs2_data;
    logic [REG_NUM_BITWIDTH-1:0] rd;
    logic                        busy;
    logic                        done;
    logic [WORD_BITWIDTH-1:0]    result;
    logic [REG_NUM_BITWIDTH-1:0] result_rd;
    logic                        reg_write;

    modport master (
        output start, funct3, rs1_data, rs2_data, rd,
        input  busy, done, result, result_rd, reg_write
    );

    modport slave (
        input  start, funct3, rs1_data, rs2_data, rd,
        output busy, done, result, result_rd, reg_write
    );
endinterface

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative RV32M multiply/divide unit
// Radix-2 shift-add multiply and restoring divide on magnitudes, one bit per cycle.
module muldiv_unit #(
    parameter int REG_NUM_BITWIDTH = 5,
    parameter int WORD_BITWIDTH    = 32
) (
    input  logic           clk_i,
    input  logic           rst_ni,
    muldiv_unit_if.slave   bus
);
    localparam int W  = WORD_BITWIDTH;
    localparam int RW = REG_NUM_BITWIDTH;

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

    state_t          state_q, state_d;
    logic [4:0]      cnt_q, cnt_d;
    logic [1:0]      f3_q, f3_d;
    logic [RW-1:0]   rd_q, rd_d, res_rd_q, res_rd_d;
    logic [W-1:0]    opb_q, opb_d, res_q, res_d;
    logic [2*W-1:0]  acc_q, acc_d;
    logic            neg_q, neg_d, sa_q, sa_d;

    logic            a_signed, b_signed, a_neg, b_neg;
    logic [W-1:0]    mag_a, mag_b;
    logic            div_zero, div_ovf;

    logic [W:0]      mul_sum;
    logic [2*W-1:0]  mul_next, mul_fix;
    logic            div_ge;
    logic [W-1:0]    div_diff;
    logic [2*W-1:0]  div_next;
    logic [W-1:0]    quo, rem, mul_res, div_res;
    logic            last;

    // Operand signedness: MUL/MULH signed x signed, MULHSU signed x unsigned, DIV/REM signed.
    always_comb begin
        if (bus.funct3[2]) begin
            a_signed = ~bus.funct3[0];
            b_signed = ~bus.funct3[0];
        end else begin
            a_signed = (bus.funct3[1:0] != 2'b11);
            b_signed = ~bus.funct3[1];
        end
    end

    assign a_neg    = a_signed & bus.rs1_data[W-1];
    assign b_neg    = b_signed & bus.rs2_data[W-1];
    assign mag_a    = a_neg ? -bus.rs1_data : bus.rs1_data;
    assign mag_b    = b_neg ? -bus.rs2_data : bus.rs2_data;
    assign div_zero = (bus.rs2_data == '0);
    assign div_ovf  = ~bus.funct3[0] && (bus.rs1_data == {1'b1, {(W-1){1'b0}}}) &&
                      (bus.rs2_data == '1);

    // Multiply: multiplier sits in acc low half and shifts out as the product shifts in.
    assign mul_sum  = {1'b0, acc_q[2*W-1:W]} + (acc_q[0] ? {1'b0, opb_q} : '0);
    assign mul_next = {mul_sum, acc_q[W-1:1]};
    assign mul_fix  = neg_q ? -mul_next : mul_next;
    assign mul_res  = (f3_q == 2'b00) ? mul_fix[W-1:0] : mul_fix[2*W-1:W];

    // Divide: acc = {remainder, dividend/quotient}; the difference always fits W bits when taken.
    assign div_ge   = (acc_q[2*W-1:W-1] >= {1'b0, opb_q});
    assign div_diff = acc_q[2*W-2:W-1] - opb_q;
    assign div_next = div_ge ? {div_diff, acc_q[W-2:0], 1'b1} : {acc_q[2*W-2:0], 1'b0};
    assign quo      = div_next[W-1:0];
    assign rem      = div_next[2*W-1:W];
    assign div_res  = f3_q[1] ? (sa_q ? -rem : rem) : (neg_q ? -quo : quo);

    assign last = (cnt_q == 5'd31);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        f3_d     = f3_q;
        rd_d     = rd_q;
        res_rd_d = res_rd_q;
        opb_d    = opb_q;
        res_d    = res_q;
        acc_d    = acc_q;
        neg_d    = neg_q;
        sa_d     = sa_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                state_d = S_IDLE;
                if (bus.start) begin
                    f3_d  = bus.funct3[1:0];
                    rd_d  = bus.rd;
                    cnt_d = '0;
                    neg_d = a_neg ^ b_neg;
                    sa_d  = a_neg;
                    if (bus.funct3[2]) begin
                        acc_d = {{W{1'b0}}, mag_a};
                        opb_d = mag_b;
                        if (div_zero) begin
                            res_d    = bus.funct3[1] ? bus.rs1_data : '1;
                            res_rd_d = bus.rd;
                            state_d  = S_DONE;
                        end else if (div_ovf) begin
                            res_d    = bus.funct3[1] ? '0 : bus.rs1_data;
                            res_rd_d = bus.rd;
                            state_d  = S_DONE;
                        end else begin
                            state_d = S_DIV;
                        end
                    end else begin
                        acc_d   = {{W{1'b0}}, mag_b};
                        opb_d   = mag_a;
                        state_d = S_MUL;
                    end
                end
            end
            S_MUL: begin
                acc_d = mul_next;
                cnt_d = cnt_q + 5'd1;
                if (last) begin
                    res_d    = mul_res;
                    res_rd_d = rd_q;
                    state_d  = S_DONE;
                end
            end
            S_DIV: begin
                acc_d = div_next;
                cnt_d = cnt_q + 5'd1;
                if (last) begin
                    res_d    = div_res;
                    res_rd_d = rd_q;
                    state_d  = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            f3_q     <= '0;
            rd_q     <= '0;
            res_rd_q <= '0;
            opb_q    <= '0;
            res_q    <= '0;
            acc_q    <= '0;
            neg_q    <= 1'b0;
            sa_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            f3_q     <= f3_d;
            rd_q     <= rd_d;
            res_rd_q <= res_rd_d;
            opb_q    <= opb_d;
            res_q    <= res_d;
            acc_q    <= acc_d;
            neg_q    <= neg_d;
            sa_q     <= sa_d;
        end
    end

    assign bus.busy      = (state_q == S_MUL) || (state_q == S_DIV);
    assign bus.done      = (state_q == S_DONE);
    assign bus.result    = res_q;
    assign bus.result_rd = res_rd_q;
    assign bus.reg_write = (state_q == S_DONE) && (res_rd_q != '0);
endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - self-checking bench for muldiv_unit against an arithmetic reference model
module tb_muldiv_unit;
    logic clk_i = 1'b0;
    logic rst_ni;
    int   errors = 0;
    int   checks = 0;

    muldiv_unit_if #(.REG_NUM_BITWIDTH(5), .WORD_BITWIDTH(32)) bus ();

    muldiv_unit #(.REG_NUM_BITWIDTH(5), .WORD_BITWIDTH(32)) dut (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .bus    (bus)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // RISC-V M-extension semantics from 64-bit integer arithmetic.
    function automatic logic [31:0] ref_model(input logic [2:0] f3, input logic [31:0] a,
                                              input logic [31:0] b);
        longint          sa, sb, p;
        longint unsigned ua, ub, up;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        case (f3)
            3'd0: begin p = sa * sb; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * longint'(ub); return p[63:32]; end
            3'd3: begin up = ua * ub; return up[63:32]; end
            3'd4: begin
                if (b == 32'd0) return 32'hFFFFFFFF;
                if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h80000000;
                p = sa / sb; return p[31:0];
            end
            3'd5: begin
                if (b == 32'd0) return 32'hFFFFFFFF;
                return a / b;
            end
            3'd6: begin
                if (b == 32'd0) return a;
                if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'd0;
                p = sa % sb; return p[31:0];
            end
            default: begin
                if (b == 32'd0) return a;
                return a % b;
            end
        endcase
    endfunction

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 5))
            0:       return 32'd0;
            1:       return 32'h80000000;
            2:       return 32'hFFFFFFFF;
            3:       return $urandom_range(0, 20);
            default: return $urandom;
        endcase
    endfunction

    // Caller is at a falling edge; the request is sampled on the next rising edge (E0).
    task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] rd, input string tag);
        logic [31:0] exp;
        logic        fast;
        int          n, nbusy;
        exp  = ref_model(f3, a, b);
        fast = f3[2] && ((b == 32'd0) || (!f3[0] && a == 32'h80000000 && b == 32'hFFFFFFFF));
        bus.start = 1'b1; bus.funct3 = f3; bus.rs1_data = a; bus.rs2_data = b; bus.rd = rd;
        @(posedge clk_i);
        #1;
        bus.start = 1'b0; bus.funct3 = 3'($urandom); bus.rs1_data = $urandom;
        bus.rs2_data = $urandom; bus.rd = 5'($urandom);
        n = 0;
        nbusy = 0;
        do begin
            @(negedge clk_i);
            n++;
            if (bus.busy) nbusy++;
        end while (!bus.done && n < 40);
        check({tag, "/latency"}, 64'(n), fast ? 64'd1 : 64'd33);
        check({tag, "/busy_cycles"}, 64'(nbusy), fast ? 64'd0 : 64'd32);
        check({tag, "/result"}, 64'(bus.result), 64'(exp));
        check({tag, "/result_rd"}, 64'(bus.result_rd), 64'(rd));
        check({tag, "/reg_write"}, 64'(bus.reg_write), 64'(rd != 5'd0));
    endtask

    initial begin
        int          ndone;
        logic [31:0] held;
        logic [2:0]  f3;
        rst_ni = 1'b0;
        bus.start = 1'b0; bus.funct3 = '0; bus.rs1_data = '0; bus.rs2_data = '0; bus.rd = '0;
        repeat (2) @(negedge clk_i);
        check("reset/busy", 64'(bus.busy), 64'd0);
        check("reset/done", 64'(bus.done), 64'd0);
        check("reset/reg_write", 64'(bus.reg_write), 64'd0);
        check("reset/result", 64'(bus.result), 64'd0);
        check("reset/result_rd", 64'(bus.result_rd), 64'd0);
        rst_ni = 1'b1;
        @(negedge clk_i);

        run_op(3'd0, 32'd7, 32'hFFFFFFFD, 5'd5, "mul_7x-3");
        held = bus.result;
        repeat (3) @(negedge clk_i);
        check("hold/done_low", 64'(bus.done), 64'd0);
        check("hold/result", 64'(bus.result), 64'(held));
        run_op(3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd1, "mulhu");
        run_op(3'd1, 32'h80000000, 32'h80000000, 5'd2, "mulh");
        run_op(3'd2, 32'hFFFFFFFF, 32'h00000002, 5'd3, "mulhsu");
        run_op(3'd4, 32'hFFFFFFF9, 32'd2, 5'd4, "div_-7/2");
        run_op(3'd6, 32'hFFFFFFF9, 32'd2, 5'd6, "rem_-7/2");
        run_op(3'd5, 32'hFFFFFFF9, 32'd2, 5'd7, "divu");
        run_op(3'd7, 32'hFFFFFFF9, 32'd2, 5'd8, "remu");
        run_op(3'd5, 32'd1234, 32'd0, 5'd9, "divu_by0");
        run_op(3'd7, 32'd1234, 32'd0, 5'd10, "remu_by0");
        run_op(3'd4, 32'h80000000, 32'hFFFFFFFF, 5'd11, "div_ovf");
        run_op(3'd6, 32'h80000000, 32'hFFFFFFFF, 5'd12, "rem_ovf");
        run_op(3'd0, 32'd9, 32'd9, 5'd0, "mul_rd0");
        @(negedge clk_i);

        // A second request mid-operation must be dropped.
        bus.start = 1'b1; bus.funct3 = 3'd0; bus.rs1_data = 32'd5; bus.rs2_data = 32'd6; bus.rd = 5'd3;
        @(posedge clk_i);
        #1 bus.start = 1'b0;
        repeat (4) @(negedge clk_i);
        bus.start = 1'b1; bus.funct3 = 3'd5; bus.rs1_data = 32'd100; bus.rs2_data = 32'd0; bus.rd = 5'd4;
        @(posedge clk_i);
        #1 bus.start = 1'b0;
        ndone = 0;
        repeat (40) begin
            @(negedge clk_i);
            if (bus.done) ndone++;
        end
        check("ignore/done_count", 64'(ndone), 64'd1);
        check("ignore/result", 64'(bus.result), 64'd30);
        check("ignore/result_rd", 64'(bus.result_rd), 64'd3);

        // Reset in the middle of a divide.
        bus.start = 1'b1; bus.funct3 = 3'd4; bus.rs1_data = 32'd1000; bus.rs2_data = 32'd7; bus.rd = 5'd13;
        @(posedge clk_i);
        #1 bus.start = 1'b0;
        repeat (10) @(negedge clk_i);
        rst_ni = 1'b0;
        #1;
        check("abort/busy", 64'(bus.busy), 64'd0);
        check("abort/done", 64'(bus.done), 64'd0);
        check("abort/result", 64'(bus.result), 64'd0);
        check("abort/result_rd", 64'(bus.result_rd), 64'd0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(negedge clk_i);
        run_op(3'd0, 32'd3, 32'd4, 5'd14, "after_abort");

        // Random operations, some issued back-to-back in the DONE cycle.
        for (int i = 0; i < 40; i++) begin
            f3 = 3'($urandom_range(0, 7));
            run_op(f3, pick_operand(), pick_operand(), 5'($urandom), $sformatf("rand%0d_f%0d", i, f3));
            if ($urandom_range(0, 1) == 1) @(negedge clk_i);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
